cpu_state_ctrl: RTL and testbench
=================================

// Module: cpu_state_ctrl
// PURPOSE
//   Multicycle sequencer for the MIPS CPU. It steps the datapath through FETCH/DECODE/EXEC/MEM/COMMIT.
//   It drives the 3-bit State bus consumed by the PC unit, which updates the PC when State==5.
//   It issues memory read/write strobes and holds on bus waitrequest and divider busy.
//   It detects halt (fetch from address 0) and bus-timeout faults, and counts retired instructions.
// PARAMETERS
//   WAIT_LIMIT  1024  consecutive waitrequest cycles in FETCH/MEM before FAULT; 0 = never time out
//   CNT_W       32    width of instr_count
// PORTS
//   clk           in   1      single system clock; all state updates on posedge
//   reset         in   1      asynchronous, active-low reset
//   waitrequest   in   1      memory bus stall; meaningful only in FETCH and MEM
//   opcode        in   6      Instruction[31:26] of the latched instruction register
//   div_busy      in   1      multicycle MULT/DIV unit still computing
//   pc            in   32     current RegPC from the PC unit
//   state         out  3      0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC, 4 MEM, 5 COMMIT, 6 HALT, 7 FAULT
//   mem_read      out  1      bus read strobe
//   mem_write     out  1      bus write strobe
//   addr_sel      out  1      0 = bus address from pc, 1 = from ALU result
//   ir_write      out  1      load instruction register this cycle
//   reg_wr_phase  out  1      register-file write-back enable window
//   active        out  1      CPU running
//   fault         out  1      sticky bus-timeout flag
//   instr_count   out  CNT_W  retired-instruction count
// BEHAVIOUR
//   Reset (reset=0, async, any cycle, including mid-transaction)
//     - state=IDLE; active=0; fault=0; instr_count=0; wait counter=0.
//     - All strobes drop immediately.
//   Strobe decode
//     - mem_read, mem_write, addr_sel, ir_write and reg_wr_phase are combinational decodes of the registered state and inputs.
//     - active, fault and instr_count are registered.
//   Load/store classification
//     - load:  opcode in {0x20,0x21,0x22,0x23,0x24,0x25,0x26}
//     - store: opcode in {0x28,0x29,0x2B}
//   State transitions
//     - IDLE -> FETCH unconditionally; active<=1.
//     - FETCH, pc==0: -> HALT; mem_read=0; no read issued.
//     - FETCH, otherwise: mem_read=1, addr_sel=0.
//       - waitrequest=1: stay.
//       - waitrequest=0: ir_write=1, -> DECODE.
//     - DECODE -> EXEC.
//     - EXEC: stay while div_busy=1; else -> MEM if load/store, else -> COMMIT.
//     - MEM: addr_sel=1; mem_read=load, mem_write=store.
//       - Strobes held stable while waitrequest=1.
//       - waitrequest=0: -> COMMIT.
//     - COMMIT: reg_wr_phase=1; instr_count<=instr_count+1 (wraps at 2^CNT_W); -> FETCH.
//     - HALT: active<=0; all strobes 0; terminal until reset.
//     - FAULT: active<=0; fault<=1; all strobes 0; terminal until reset.
//   Latency (zero wait states)
//     - ALU/branch/jump instruction: 4 cycles.
//     - Load/store: 5 cycles.
//     - Each waitrequest or div_busy cycle adds one cycle.
//   Wait counter
//     - Increments on each FETCH/MEM cycle with waitrequest=1.
//     - Clears on any cycle without such a stall.
//     - WAIT_LIMIT!=0 and counter reaches WAIT_LIMIT-1 while stalled: -> FAULT next edge (stall cycle WAIT_LIMIT is the last in FETCH/MEM).
//   Input qualification
//     - waitrequest is ignored outside FETCH/MEM.
//     - div_busy is ignored outside EXEC.
//     - opcode is sampled only in EXEC and MEM; it must stay stable from DECODE through COMMIT.
//   Simultaneous events
//     - FETCH with pc==0 and waitrequest=1 -> HALT; halt wins.
//     - Timeout in MEM: the store is aborted, mem_write drops in FAULT, and instr_count does not increment.
// TESTING
//   1. reset release, pc=BFC00000, opcode=0x00, waitrequest=0
//      -> state 0,1,2,3,5,1; ir_write in cycle 1; instr_count=1 after COMMIT.
//   2. LW (0x23), waitrequest=1 for 3 MEM cycles
//      -> MEM held 4 cycles, mem_read=1 and addr_sel=1 throughout, mem_write=0, then COMMIT.
//   3. SW (0x2B), no wait -> exactly one MEM cycle with mem_write=1, mem_read=0.
//   4. DIV with div_busy=1 for 10 cycles -> state=3 for 11 cycles, then 5; no strobes during EXEC.
//   5. pc=0 on entering FETCH -> HALT next edge, active=0, mem_read never asserted, state stays 6.
//   6. WAIT_LIMIT=8, waitrequest stuck in FETCH -> state=7 after 8 stall cycles, fault=1, active=0.
//      Then reset=0 mid-MEM of a SW -> state=0 and mem_write=0 without a clock edge.

Source files
------------

// File: rtl/cpu_state_ctrl.sv
// Multicycle sequencer for the MIPS core: steps FETCH/DECODE/EXEC/MEM/COMMIT,
// issues bus strobes, tracks halt/bus-timeout faults and counts retired instructions.
module cpu_state_ctrl #(
  parameter int unsigned WAIT_LIMIT = 1024,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             waitrequest,
  input  logic [5:0]       opcode,
  input  logic             div_busy,
  input  logic [31:0]      pc,
  output logic [2:0]       state,
  output logic             mem_read,
  output logic             mem_write,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             reg_wr_phase,
  output logic             active,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_COMMIT = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam int WCW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [WCW-1:0] LIMIT_M1 = (WAIT_LIMIT == 0) ? '0 : WCW'(WAIT_LIMIT - 1);

  state_t         cur;
  state_t         nxt;
  logic [WCW-1:0] wait_cnt;
  logic           is_load;
  logic           is_store;
  logic           fetch_go;
  logic           stall;
  logic           timeout;

  assign is_load  = opcode inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26};
  assign is_store = opcode inside {6'h28, 6'h29, 6'h2B};
  // A fetch from address 0 is a halt, so it never counts as a bus stall.
  assign fetch_go = (cur == S_FETCH) && (pc != 32'h0);
  assign stall    = waitrequest && (fetch_go || (cur == S_MEM));
  assign timeout  = (WAIT_LIMIT != 0) && stall && (wait_cnt == LIMIT_M1);
  assign state    = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH: begin
        if (pc == 32'h0)       nxt = S_HALT;
        else if (timeout)      nxt = S_FAULT;
        else if (!waitrequest) nxt = S_DECODE;
      end
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        if (!div_busy) nxt = (is_load || is_store) ? S_MEM : S_COMMIT;
      end
      S_MEM: begin
        if (timeout)           nxt = S_FAULT;
        else if (!waitrequest) nxt = S_COMMIT;
      end
      S_COMMIT: nxt = S_FETCH;
      default:  nxt = cur;
    endcase
  end

  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    addr_sel     = 1'b0;
    ir_write     = 1'b0;
    reg_wr_phase = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read = fetch_go;
        ir_write = fetch_go && !waitrequest;
      end
      S_MEM: begin
        addr_sel  = 1'b1;
        mem_read  = is_load;
        mem_write = is_store;
      end
      S_COMMIT: reg_wr_phase = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt    <= '0;
      active      <= 1'b0;
      fault       <= 1'b0;
      instr_count <= '0;
    end else begin
      wait_cnt <= stall ? wait_cnt + 1'b1 : '0;
      active   <= (nxt != S_IDLE) && (nxt != S_HALT) && (nxt != S_FAULT);
      fault    <= fault || (nxt == S_FAULT);
      if (cur == S_COMMIT) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_state_ctrl.sv
// Randomized scoreboard bench for cpu_state_ctrl: a phase-level instruction model
// plans inputs and expected outputs per cycle; a negedge monitor compares.
module tb_cpu_state_ctrl;

  localparam int WL = 8;
  localparam int CW = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_COMMIT = 3'd5, S_HALT = 3'd6, S_FAULT = 3'd7;

  logic          clk;
  logic          reset;
  logic          waitrequest;
  logic [5:0]    opcode;
  logic          div_busy;
  logic [31:0]   pc;
  logic [2:0]    state;
  logic          mem_read;
  logic          mem_write;
  logic          addr_sel;
  logic          ir_write;
  logic          reg_wr_phase;
  logic          active;
  logic          fault;
  logic [CW-1:0] instr_count;

  cpu_state_ctrl #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .opcode(opcode),
    .div_busy(div_busy), .pc(pc), .state(state), .mem_read(mem_read),
    .mem_write(mem_write), .addr_sel(addr_sel), .ir_write(ir_write),
    .reg_wr_phase(reg_wr_phase), .active(active), .fault(fault),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        rd, wr, as, iw, rw, act, flt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   m_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("state_strobes",
          64'({state, mem_read, mem_write, addr_sel, ir_write, reg_wr_phase, active, fault}),
          64'({e.st, e.rd, e.wr, e.as, e.iw, e.rw, e.act, e.flt}));
      chk("instr_count", 64'(instr_count), 64'(e.cnt));
    end
  end

  task automatic put(input logic [2:0] st, input logic rd, wr, as, iw, rw, act, flt,
                     input logic wq, dbz, input logic [31:0] pcv, input logic [5:0] op);
    exp_t e;
    waitrequest = wq;
    div_busy    = dbz;
    pc          = pcv;
    opcode      = op;
    e.st = st; e.rd = rd; e.wr = wr; e.as = as; e.iw = iw; e.rw = rw;
    e.act = act; e.flt = flt;
    e.cnt = 32'(m_cnt % (1 << CW));
    sb.push_back(e);
  endtask

  task automatic step(input logic [2:0] st, input logic rd, wr, as, iw, rw, act, flt,
                      input logic wq, dbz, input logic [31:0] pcv, input logic [5:0] op);
    @(posedge clk);
    #1;
    put(st, rd, wr, as, iw, rw, act, flt, wq, dbz, pcv, op);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    put(S_IDLE, 0, 0, 0, 0, 0, 0, 0, rb(), rb(), $urandom, 6'($urandom));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset", 64'({state, mem_read, mem_write, active, fault, instr_count}), 64'd0);
    m_cnt = 0;
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  task automatic fault_tail();
    repeat (3) step(S_FAULT, 0, 0, 0, 0, 0, 0, 1, rb(), rb(), $urandom, 6'($urandom));
  endtask

  // One instruction at phase level: fw fetch stalls, dn divider-busy cycles, mw memory stalls.
  task automatic run_instr(input logic [5:0] op, input logic [31:0] pcv,
                           input int fw, input int dn, input int mw, output bit dead);
    bit ld, st_op;
    ld    = op inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26};
    st_op = op inside {6'h28, 6'h29, 6'h2B};
    dead  = 1'b0;
    if (pcv == 32'h0) begin
      step(S_FETCH, 0, 0, 0, 0, 0, 1, 0, rb(), rb(), 32'h0, 6'($urandom));
      repeat (3) step(S_HALT, 0, 0, 0, 0, 0, 0, 0, rb(), rb(), $urandom, 6'($urandom));
      dead = 1'b1;
      return;
    end
    for (int i = 0; i < fw && i < WL; i++)
      step(S_FETCH, 1, 0, 0, 0, 0, 1, 0, 1, rb(), pcv, 6'($urandom));
    if (fw >= WL) begin
      fault_tail();
      dead = 1'b1;
      return;
    end
    step(S_FETCH, 1, 0, 0, 1, 0, 1, 0, 0, rb(), pcv, 6'($urandom));
    step(S_DECODE, 0, 0, 0, 0, 0, 1, 0, rb(), rb(), pcv, op);
    for (int i = 0; i < dn; i++)
      step(S_EXEC, 0, 0, 0, 0, 0, 1, 0, rb(), 1, pcv, op);
    step(S_EXEC, 0, 0, 0, 0, 0, 1, 0, rb(), 0, pcv, op);
    if (ld || st_op) begin
      for (int i = 0; i < mw && i < WL; i++)
        step(S_MEM, ld, st_op, 1, 0, 0, 1, 0, 1, rb(), pcv, op);
      if (mw >= WL) begin
        fault_tail();
        dead = 1'b1;
        return;
      end
      step(S_MEM, ld, st_op, 1, 0, 0, 1, 0, 0, rb(), pcv, op);
    end
    step(S_COMMIT, 0, 0, 0, 0, 1, 1, 0, rb(), rb(), pcv, op);
    m_cnt++;
  endtask

  logic [5:0] op_pool [16] = '{6'h00, 6'h23, 6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26,
                               6'h2B, 6'h28, 6'h29, 6'h08, 6'h04, 6'h02, 6'h2A, 6'h27};

  initial begin
    bit dead;
    logic [5:0] op;
    int fw, dn, mw;
    reset = 1'b0; waitrequest = 1'b0; opcode = '0; div_busy = 1'b0; pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", 64'({state, active, fault, instr_count}), 64'd0);
    release_reset();

    run_instr(6'h00, 32'hBFC0_0000, 0, 0, 0, dead);
    run_instr(6'h23, 32'hBFC0_0004, 0, 0, 3, dead);
    run_instr(6'h2B, 32'hBFC0_0008, 0, 0, 0, dead);
    run_instr(6'h00, 32'hBFC0_000C, 0, 10, 0, dead);
    run_instr(6'h2B, 32'hBFC0_0010, WL - 1, 0, WL - 1, dead);

    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 15)];
      fw = ($urandom_range(0, 4) == 0) ? WL - 1 : $urandom_range(0, 3);
      dn = $urandom_range(0, 1) ? $urandom_range(1, 4) : 0;
      mw = ($urandom_range(0, 4) == 0) ? WL - 1 : $urandom_range(0, 4);
      run_instr(op, $urandom | 32'h4, fw, dn, mw, dead);
    end
    run_instr(6'h23, 32'h0, 0, 0, 0, dead);

    do_reset();
    run_instr(6'h00, 32'h0040_0000, WL, 0, 0, dead);

    do_reset();
    run_instr(6'h21, 32'h0040_0000, 1, 0, 2, dead);
    run_instr(6'h2B, 32'h0040_0004, 0, 0, WL, dead);

    do_reset();
    step(S_FETCH, 1, 0, 0, 1, 0, 1, 0, 0, 0, 32'h0040_0100, 6'h2B);
    step(S_DECODE, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0040_0100, 6'h2B);
    step(S_EXEC, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0040_0100, 6'h2B);
    step(S_MEM, 0, 1, 1, 0, 0, 1, 0, 1, 0, 32'h0040_0100, 6'h2B);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_mem_reset", 64'({state, mem_write, mem_read, addr_sel, active}), 64'd0);
    m_cnt = 0;
    repeat (2) @(posedge clk);
    release_reset();
    run_instr(6'h28, 32'h0040_0200, 0, 0, 1, dead);

    @(negedge clk);
    #1;
    chk("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
